// File: rtl/cpu_cu_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_cu_if
//  Description : Bus between the CPU control unit and the execution unit.
//                Carries the IR contents and live ALU flags into the control
//                unit, and the control strobes, debug state and registered
//                flags back out.
//                  master : control-unit side (drives strobes)
//                  slave  : execution-unit side (drives ir and C/N/Z)
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_cu_if;

    logic [15:0] ir;        // instruction register; [11:9] = instruction class
    logic        C;         // ALU carry (live)
    logic        N;         // ALU negative (live)
    logic        Z;         // ALU zero (live)

    logic        adr_sel;   // 0 = PC, 1 = register R
    logic        s_sel;     // 0 = register S, 1 = memory data
    logic        pc_ld;     // load PC from ALU output
    logic        pc_inc;    // increment PC
    logic        reg_W_en;  // register file write enable
    logic        ir_ld;     // load IR from memory data
    logic        mw_en;     // RAM write enable
    logic        halt;      // high while halted
    logic [3:0]  state;     // current state code (debug)
    logic [2:0]  flags;     // registered {C,N,Z}

    modport master (
        input  ir, C, N, Z,
        output adr_sel, s_sel, pc_ld, pc_inc, reg_W_en, ir_ld, mw_en,
               halt, state, flags
    );

    modport slave (
        output ir, C, N, Z,
        input  adr_sel, s_sel, pc_ld, pc_inc, reg_W_en, ir_ld, mw_en,
               halt, state, flags
    );

endinterface
`default_nettype wire

// File: rtl/cpu_cu.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_cu
//  Description : Control unit for the 16-bit CPU. Moore state machine that
//                sequences FETCH -> DECODE -> EX_* and drives the execution
//                unit's strobes and the RAM write enable. Holds a flag
//                register that captures the ALU {C,N,Z} only on EX_ALU.
//  Ports       : clk    - system clock, rising edge
//                reset  - asynchronous, active-low reset
//                step   - single-step advance pulse (CU_SINGLE_STEP_EN only)
//                bus    - cpu_cu_if.master: ir, C/N/Z in; strobes, halt,
//                         state and flags out
//  Options     : CU_SINGLE_STEP_EN - when defined, every EX_* state parks in
//                STEP_WAIT until a step pulse arrives.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_cu (
    input  wire        clk,
    input  wire        reset,
`ifdef CU_SINGLE_STEP_EN
    input  wire        step,
`endif
    cpu_cu_if.master   bus
);

    typedef enum logic [3:0] {
        ST_RESET     = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EX_ALU    = 4'd3,
        ST_EX_LOAD   = 4'd4,
        ST_EX_STORE  = 4'd5,
        ST_EX_JMP    = 4'd6,
        ST_EX_BR     = 4'd7,
        ST_HALT      = 4'd8,
        ST_STEP_WAIT = 4'd9
    } state_t;

    localparam logic [2:0] c_CLS_ALU   = 3'b000;
    localparam logic [2:0] c_CLS_LOAD  = 3'b001;
    localparam logic [2:0] c_CLS_STORE = 3'b010;
    localparam logic [2:0] c_CLS_JMP   = 3'b011;
    localparam logic [2:0] c_CLS_BR_Z  = 3'b100;
    localparam logic [2:0] c_CLS_BR_N  = 3'b101;
    localparam logic [2:0] c_CLS_BR_C  = 3'b110;
    localparam logic [2:0] c_CLS_HALT  = 3'b111;

    // Where every execute state goes once it has issued its strobes.
`ifdef CU_SINGLE_STEP_EN
    localparam state_t c_AFTER_EX = ST_STEP_WAIT;
`else
    localparam state_t c_AFTER_EX = ST_FETCH;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_flags;       // {C,N,Z}
    logic [2:0]  w_cls;

    logic        w_adr_sel;
    logic        w_s_sel;
    logic        w_pc_ld;
    logic        w_pc_inc;
    logic        w_reg_W_en;
    logic        w_ir_ld;
    logic        w_mw_en;
    logic        w_halt;

    // The ALU op field and immediate bits belong to the execution unit.
    logic        w_unused_ir;
    assign w_unused_ir = ^{bus.ir[15:12], bus.ir[8:0]};

    // IR is loaded only on the FETCH edge, so the class field stays valid
    // through DECODE and the following execute state.
    assign w_cls = bus.ir[11:9];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Flag register: captures the live ALU flags only as EX_ALU retires.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 3'b000;
        end else if (r_state == ST_EX_ALU) begin
            r_flags <= {bus.C, bus.N, bus.Z};
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore outputs. Strobes come straight from the state
    // register, so an asynchronous reset drops them without a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = ST_RESET;
        w_adr_sel  = 1'b0;
        w_s_sel    = 1'b0;
        w_pc_ld    = 1'b0;
        w_pc_inc   = 1'b0;
        w_reg_W_en = 1'b0;
        w_ir_ld    = 1'b0;
        w_mw_en    = 1'b0;
        w_halt     = 1'b0;

        case (r_state)
            ST_RESET: begin
                w_next = ST_FETCH;
            end

            ST_FETCH: begin
                // RAM read is combinational: IR captures the word at the
                // current PC on the same edge that increments it.
                w_adr_sel = 1'b0;
                w_ir_ld   = 1'b1;
                w_pc_inc  = 1'b1;
                w_next    = ST_DECODE;
            end

            ST_DECODE: begin
                case (w_cls)
                    c_CLS_ALU:   w_next = ST_EX_ALU;
                    c_CLS_LOAD:  w_next = ST_EX_LOAD;
                    c_CLS_STORE: w_next = ST_EX_STORE;
                    c_CLS_JMP:   w_next = ST_EX_JMP;
                    c_CLS_BR_Z,
                    c_CLS_BR_N,
                    c_CLS_BR_C:  w_next = ST_EX_BR;
                    c_CLS_HALT:  w_next = ST_HALT;
                    default:     w_next = ST_HALT;
                endcase
            end

            ST_EX_ALU: begin
                w_s_sel    = 1'b0;
                w_reg_W_en = 1'b1;
                w_next     = c_AFTER_EX;
            end

            ST_EX_LOAD: begin
                w_adr_sel  = 1'b1;
                w_s_sel    = 1'b1;
                w_reg_W_en = 1'b1;
                w_next     = c_AFTER_EX;
            end

            ST_EX_STORE: begin
                w_adr_sel = 1'b1;
                w_mw_en   = 1'b1;
                w_next    = c_AFTER_EX;
            end

            ST_EX_JMP: begin
                w_pc_ld = 1'b1;
                w_next  = c_AFTER_EX;
            end

            ST_EX_BR: begin
                // Condition uses the registered flags, never the live ALU
                // outputs, so the result of the last ALU op decides.
                case (w_cls)
                    c_CLS_BR_Z: w_pc_ld = r_flags[0];
                    c_CLS_BR_N: w_pc_ld = r_flags[1];
                    c_CLS_BR_C: w_pc_ld = r_flags[2];
                    default:    w_pc_ld = 1'b0;
                endcase
                w_next = c_AFTER_EX;
            end

            ST_HALT: begin
                w_halt = 1'b1;
                w_next = ST_HALT;
            end

            ST_STEP_WAIT: begin
`ifdef CU_SINGLE_STEP_EN
                w_next = step ? ST_FETCH : ST_STEP_WAIT;
`else
                // Unreachable without single-step; treat as illegal.
                w_next = ST_RESET;
`endif
            end

            default: begin
                w_next = ST_RESET;
            end
        endcase
    end

    assign bus.adr_sel  = w_adr_sel;
    assign bus.s_sel    = w_s_sel;
    assign bus.pc_ld    = w_pc_ld;
    assign bus.pc_inc   = w_pc_inc;
    assign bus.reg_W_en = w_reg_W_en;
    assign bus.ir_ld    = w_ir_ld;
    assign bus.mw_en    = w_mw_en;
    assign bus.halt     = w_halt;
    assign bus.state    = r_state;
    assign bus.flags    = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_cpu_cu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_cu
//  Description : Self-checking bench for cpu_cu. Instruction vectors are
//                applied from a table; halt and mid-instruction reset are
//                hand-written sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_cu;

    // Output bit order: {halt, adr_sel, s_sel, pc_ld, pc_inc, reg_W_en, ir_ld, mw_en}
    localparam logic [7:0] c_O_NONE  = 8'b0000_0000;
    localparam logic [7:0] c_O_FETCH = 8'b0000_1010;
    localparam logic [7:0] c_O_ALU   = 8'b0000_0100;
    localparam logic [7:0] c_O_LOAD  = 8'b0110_0100;
    localparam logic [7:0] c_O_STORE = 8'b0100_0001;
    localparam logic [7:0] c_O_PCLD  = 8'b0001_0000;
    localparam logic [7:0] c_O_HALT  = 8'b1000_0000;

    localparam int c_NVEC = 13;

    typedef struct {
        logic [15:0] ir;
        logic [2:0]  cnz;        // live {C,N,Z} driven through the instruction
        logic [3:0]  ex_state;
        logic [7:0]  ex_out;
        logic [2:0]  flags_after;
    } vec_t;

    logic clk;
    logic reset;
`ifdef CU_SINGLE_STEP_EN
    logic step;
`endif

    int n_checks;
    int n_errors;

    vec_t vecs [c_NVEC];

    cpu_cu_if bus ();

    cpu_cu dut (
        .clk   (clk),
        .reset (reset),
`ifdef CU_SINGLE_STEP_EN
        .step  (step),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] es,
                         input logic [7:0] eo, input logic [2:0] ef);
        logic [7:0] ao;
        ao = {bus.halt, bus.adr_sel, bus.s_sel, bus.pc_ld, bus.pc_inc,
              bus.reg_W_en, bus.ir_ld, bus.mw_en};
        n_checks++;
        if (bus.state !== es || ao !== eo || bus.flags !== ef) begin
            n_errors++;
            $display("FAIL %s: got state=%0d out=%b flags=%b, want state=%0d out=%b flags=%b",
                     name, bus.state, ao, bus.flags, es, eo, ef);
        end
    endtask

    initial begin
        logic [2:0] prev_flags;

        n_checks = 0;
        n_errors = 0;

        //           ir        cnz     ex   out        flags after
        vecs[0]  = '{16'h0000, 3'b001, 4'd3, c_O_ALU,   3'b001};  // ALU, Z
        vecs[1]  = '{16'h0200, 3'b110, 4'd4, c_O_LOAD,  3'b001};  // LOAD
        vecs[2]  = '{16'h0400, 3'b111, 4'd5, c_O_STORE, 3'b001};  // STORE
        vecs[3]  = '{16'h0800, 3'b000, 4'd7, c_O_PCLD,  3'b001};  // BR Z taken
        vecs[4]  = '{16'h0600, 3'b000, 4'd6, c_O_PCLD,  3'b001};  // JMP
        vecs[5]  = '{16'hA000, 3'b110, 4'd3, c_O_ALU,   3'b110};  // ALU, C N
        vecs[6]  = '{16'h0800, 3'b001, 4'd7, c_O_NONE,  3'b110};  // BR Z, live Z ignored
        vecs[7]  = '{16'h0A00, 3'b000, 4'd7, c_O_PCLD,  3'b110};  // BR N taken
        vecs[8]  = '{16'h0C00, 3'b000, 4'd7, c_O_PCLD,  3'b110};  // BR C taken
        vecs[9]  = '{16'h1000, 3'b010, 4'd3, c_O_ALU,   3'b010};  // ALU, N
        vecs[10] = '{16'h0C00, 3'b100, 4'd7, c_O_NONE,  3'b010};  // BR C not taken
        vecs[11] = '{16'h0A00, 3'b000, 4'd7, c_O_PCLD,  3'b010};  // BR N taken
        vecs[12] = '{16'h0800, 3'b000, 4'd7, c_O_NONE,  3'b010};  // BR Z not taken

        reset  = 1'b0;
        bus.ir = 16'h0000;
        bus.C  = 1'b0;
        bus.N  = 1'b0;
        bus.Z  = 1'b0;
`ifdef CU_SINGLE_STEP_EN
        step   = 1'b0;
`endif

        // Reset held for three cycles.
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_hold", 4'd0, c_O_NONE, 3'b000);
            tick();
        end
        reset = 1'b1;
        tick();
        check("first_fetch", 4'd1, c_O_FETCH, 3'b000);

        // Table-driven instructions, entered at FETCH.
        prev_flags = 3'b000;
        for (int v = 0; v < c_NVEC; v++) begin
            bus.ir = vecs[v].ir;
            {bus.C, bus.N, bus.Z} = vecs[v].cnz;
            check("vec_fetch", 4'd1, c_O_FETCH, prev_flags);
            tick();
            check("vec_decode", 4'd2, c_O_NONE, prev_flags);
            tick();
            check("vec_execute", vecs[v].ex_state, vecs[v].ex_out, prev_flags);
            tick();
`ifdef CU_SINGLE_STEP_EN
            check("step_wait", 4'd9, c_O_NONE, vecs[v].flags_after);
            tick();
            check("step_hold", 4'd9, c_O_NONE, vecs[v].flags_after);
            step = 1'b1;
            tick();
            step = 1'b0;
`endif
            check("vec_next_fetch", 4'd1, c_O_FETCH, vecs[v].flags_after);
            prev_flags = vecs[v].flags_after;
        end

        // Mid-instruction reset during EX_STORE (flags currently 010).
        bus.ir = 16'h0400;
        {bus.C, bus.N, bus.Z} = 3'b000;
        tick();
        check("store_decode", 4'd2, c_O_NONE, 3'b010);
        tick();
        check("store_exec", 4'd5, c_O_STORE, 3'b010);
        #2;
        reset = 1'b0;
        #1;
        check("async_abort", 4'd0, c_O_NONE, 3'b000);
        tick();
        reset = 1'b1;
        check("abort_hold", 4'd0, c_O_NONE, 3'b000);
        tick();
        check("abort_refetch", 4'd1, c_O_FETCH, 3'b000);

        // Halt is terminal until reset.
        bus.ir = 16'h0E00;
        tick();
        check("halt_decode", 4'd2, c_O_NONE, 3'b000);
        tick();
        check("halt_enter", 4'd8, c_O_HALT, 3'b000);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halt_stays", 4'd8, c_O_HALT, 3'b000);
        end
        #2;
        reset = 1'b0;
        #1;
        check("halt_reset", 4'd0, c_O_NONE, 3'b000);
        tick();
        reset = 1'b1;
        tick();
        check("halt_restart", 4'd1, c_O_FETCH, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_cu.md
# cpu_cu

Control unit for the 16-bit CPU. It sequences fetch, decode and execute by driving the execution unit's control strobes and the RAM write enable. It takes the instruction register contents and the ALU C/N/Z flags back from the execution unit. The block is a Moore state machine with a registered flag store, and it sits directly upstream of the execution unit inside the CPU top level.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes occur on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- ir  input  16  instruction register contents from the execution unit. ir[15:12] is the ALU op, consumed by the EU. ir[11:9] is the instruction class, consumed here.
- C, N, Z  input  1 each  ALU carry/negative/zero flags from the execution unit (combinational).
- step  input  1  single-step advance pulse, one clk wide, synchronous. Present only with CU_SINGLE_STEP_EN.
- adr_sel  output  1  address mux select: 0 = PC, 1 = register R.
- s_sel  output  1  S-operand select: 0 = register S, 1 = memory data (din).
- pc_ld  output  1  load PC from ALU output.
- pc_inc  output  1  increment PC.
- reg_W_en  output  1  register file write enable.
- ir_ld  output  1  load IR from din.
- mw_en  output  1  RAM write enable.
- halt  output  1  high while in HALT.
- state  output  4  current state code, for debug display.
- flags  output  3  registered {C,N,Z}.

## Operation
- The state encoding is decided:
  - RESET=0, FETCH=1, DECODE=2, EX_ALU=3, EX_LOAD=4, EX_STORE=5, EX_JMP=6, EX_BR=7, HALT=8, STEP_WAIT=9.
  - Codes 10–15 are unused and go to RESET on the next edge.
- Outputs are pure functions of the state and the registered flags. Every strobe not listed for a state is 0.
- RESET: all strobes 0. Goes to FETCH.
- FETCH: adr_sel=0, ir_ld=1, pc_inc=1. Goes to DECODE.
- DECODE: all strobes 0. ir is now stable. Next state by ir[11:9]:
  - 000 → EX_ALU
  - 001 → EX_LOAD
  - 010 → EX_STORE
  - 011 → EX_JMP
  - 100, 101, 110 → EX_BR
  - 111 → HALT
- EX_ALU: s_sel=0, reg_W_en=1. The flag register captures {C,N,Z} on the same edge.
- EX_LOAD: adr_sel=1, s_sel=1, reg_W_en=1. Flags are unchanged.
- EX_STORE: adr_sel=1, mw_en=1. Flags are unchanged.
- EX_JMP: pc_ld=1.
- EX_BR: pc_ld = flags.Z for 100, flags.N for 101, flags.C for 110.
  - The condition tests the registered flags, never the live C/N/Z inputs.
- After any EX_* state: go to FETCH, or to STEP_WAIT when single-step is enabled.
- HALT: all strobes 0, halt=1. HALT is terminal until reset.
- The flag register updates only in EX_ALU.

## Timing
- Reset values:
  - state = RESET, flags = 000.
  - All strobes and halt = 0.
  - These take effect immediately on reset falling, independent of clk.
- Reset asserted mid-instruction aborts that instruction:
  - No partial write is possible, because the strobes drop asynchronously.
  - After reset deasserts, the first active edge moves RESET → FETCH.
- Every instruction takes exactly 3 cycles (FETCH, DECODE, EX_*) without single-step.
- PC increment and IR load share the FETCH edge. RAM read is combinational, so the IR captures the word at the pre-increment PC.
- Strobes are high for exactly one cycle per instruction.
- pc_ld and pc_inc are never high in the same cycle.
- A taken branch loads the PC at the end of EX_BR, and the next FETCH reads the target.

## Configuration
- CU_SINGLE_STEP_EN, when defined:
  - The step port exists.
  - Every EX_* state goes to STEP_WAIT, which holds with all strobes 0 until step=1, then goes to FETCH.
  - step in any other state is ignored.
- When undefined:
  - There is no step port.
  - EX_* goes straight to FETCH, and STEP_WAIT is unreachable. If code 9 is reached, it goes to RESET.

## Test plan
- Reset: hold reset=0 for 3 cycles, then release.
  - During reset: state=0, all strobes 0, flags=000.
  - Edge 1 after release: state=1 with ir_ld=pc_inc=1.
- ALU instruction 0x0000 with C,N,Z=0,0,1.
  - Sequence FETCH→DECODE→EX_ALU→FETCH.
  - reg_W_en=1 only in EX_ALU.
  - flags=001 after that edge.
- Load/store: ir[11:9]=001 then 010.
  - EX_LOAD shows adr_sel=1, s_sel=1, reg_W_en=1.
  - EX_STORE shows adr_sel=1, mw_en=1, reg_W_en=0.
  - flags are unchanged in both.
- Branch with registered flags.Z=1 and ir[11:9]=100: pc_ld=1 in EX_BR.
  - Repeat with Z=0: pc_ld=0.
  - Drive live Z=1 while registered Z=0: pc_ld stays 0.
- Halt: ir[11:9]=111.
  - state=8 and halt=1 from that edge onward.
  - 10 further cycles show no strobes.
  - reset=0 returns state to 0.
- Mid-instruction reset: drop reset during EX_STORE.
  - mw_en falls within the same cycle, with no clock edge needed.
  - Under CU_SINGLE_STEP_EN: state holds at 9 until a step pulse, then reaches 1 on the next edge.
